// File: rtl/status_bram_wr_ctrl.sv
// Status-record BRAM write controller: splits one DATA_W record into 32-bit BRAM beats,
// waits a fixed settle time, then pulses wr_done; keeps write/drop statistics.
module status_bram_wr_ctrl #(
  parameter int DATA_W  = 64,
  parameter int BRAM_AW = 12,
  parameter int WR_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_start,
  input  logic [31:0]        wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_done,
  output logic               busy,
  output logic               bram_en,
  output logic [3:0]         bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [31:0]        bram_wdata,
  input  logic               clear_stats,
  output logic [15:0]        wr_count,
  output logic [7:0]         drop_cnt
);

  localparam int BEATS = DATA_W / 32;

  typedef enum logic [1:0] {IDLE, BEAT, WAIT, DONE} state_t;

  state_t            state;
  logic              k;
  logic [3:0]        lat;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              drop;
  logic              last_beat;

  assign accept    = wr_start && (state == IDLE || state == DONE);
  assign drop      = wr_start && (state == BEAT || state == WAIT);
  assign last_beat = (k == 1'(BEATS - 1));

  function automatic logic [BRAM_AW-1:0] beat_addr(input logic [31:0] a, input logic idx);
    return BRAM_AW'(a * 32'(BEATS) + 32'(idx));
  endfunction

  function automatic logic [31:0] beat_word(input logic [DATA_W-1:0] d, input logic idx);
    return (idx && BEATS == 2) ? d[DATA_W-1 -: 32] : d[31:0];
  endfunction

  // Record capture: payload registers need no reset, they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= wr_addr;
      data_q <= wr_data;
    end
  end

  // Transfer FSM; beat 0 is launched straight from the request so it appears one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 1'b0;
      lat        <= 4'd0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 4'h0;
      bram_addr  <= '0;
      bram_wdata <= 32'd0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (wr_start) begin
            state      <= BEAT;
            k          <= 1'b0;
            busy       <= 1'b1;
            bram_en    <= 1'b1;
            bram_we    <= 4'hF;
            bram_addr  <= beat_addr(wr_addr, 1'b0);
            bram_wdata <= wr_data[31:0];
          end else begin
            state <= IDLE;
          end
        end
        BEAT: begin
          if (last_beat) begin
            bram_en <= 1'b0;
            bram_we <= 4'h0;
            if (WR_LAT > 0) begin
              state <= WAIT;
              lat   <= 4'd0;
            end else begin
              state   <= DONE;
              busy    <= 1'b0;
              wr_done <= 1'b1;
            end
          end else begin
            k          <= 1'b1;
            bram_addr  <= beat_addr(addr_q, 1'b1);
            bram_wdata <= beat_word(data_q, 1'b1);
          end
        end
        WAIT: begin
          if (lat == 4'(WR_LAT - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            wr_done <= 1'b1;
          end else begin
            lat <= lat + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics: clear has priority over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 16'd0;
      drop_cnt <= 8'd0;
    end else if (clear_stats) begin
      wr_count <= 16'd0;
      drop_cnt <= 8'd0;
    end else begin
      if (state == DONE)
        wr_count <= wr_count + 16'd1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
